// File: rtl/stack_pkg.sv
// +----------------------------------------------------------------------+
// | stack_pkg : shared operation encoding and pointer sizing for the     |
// |             parametrised LIFO stack                                  |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package stack_pkg;

    // Encoded as {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } op_e;

    // Occupancy counter width: must be able to represent DEPTH itself
    function automatic int ptr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lifo_regfile.sv
// +----------------------------------------------------------------------+
// | lifo_regfile : WIDTH x DEPTH storage, one synchronous write port and |
// |                one asynchronous read port; contents are not reset    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module lifo_regfile
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/param_lifo_stack.sv
// +----------------------------------------------------------------------+
// | param_lifo_stack : parametrised LIFO with push/pop/swap, top peek,   |
// |                    occupancy and sticky error flags                  |
// | Optional         : LIFO_WATERMARK_EN adds the high_water output      |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module param_lifo_stack
    import stack_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
`ifdef LIFO_WATERMARK_EN
    output logic [$clog2(DEPTH+1)-1:0] high_water,
`endif
    output logic                       overflow,
    output logic                       underflow
);

    localparam int c_CW = ptr_width(DEPTH);
    localparam int c_AW = $clog2(DEPTH);

    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_overflow;
    logic             r_underflow;

    op_e              w_op;
    logic             w_full;
    logic             w_empty;
    logic             w_we;
    logic [c_AW-1:0]  w_waddr;
    logic [c_AW-1:0]  w_top_idx;
    logic [WIDTH-1:0] w_rd_data;
    logic [c_CW-1:0]  w_count_nxt;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             w_dv_nxt;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_op    = op_e'({push, pop});
    assign w_full  = (r_count == c_CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Index held at 0 while empty so the read port never sees an out-of-range address
    assign w_top_idx = w_empty ? '0 : c_AW'(r_count - c_CW'(1));

    lifo_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_regfile (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (data_in),
        .raddr (w_top_idx),
        .rdata (w_rd_data)
    );

    always_comb begin
        w_we        = 1'b0;
        w_waddr     = w_top_idx;
        w_count_nxt = r_count;
        w_dout_nxt  = r_data_out;
        w_dv_nxt    = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        case (w_op)
            OP_PUSH: begin
                if (!w_full) begin
                    w_we        = 1'b1;
                    w_waddr     = c_AW'(r_count);
                    w_count_nxt = r_count + c_CW'(1);
                end else begin
                    w_ovf_set = 1'b1;
                end
            end
            OP_POP: begin
                if (!w_empty) begin
                    w_dout_nxt  = w_rd_data;
                    w_dv_nxt    = 1'b1;
                    w_count_nxt = r_count - c_CW'(1);
                end else begin
                    w_unf_set = 1'b1;
                end
            end
            OP_SWAP: begin
                // Replace-top; on an empty stack the word simply passes through
                w_dv_nxt = 1'b1;
                if (!w_empty) begin
                    w_dout_nxt = w_rd_data;
                    w_we       = 1'b1;
                end else begin
                    w_dout_nxt = data_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_count      <= w_count_nxt;
            r_data_out   <= w_dout_nxt;
            r_data_valid <= w_dv_nxt;
            // A new error in the clearing cycle wins over err_clr
            r_overflow   <= w_ovf_set | (r_overflow  & ~err_clr);
            r_underflow  <= w_unf_set | (r_underflow & ~err_clr);
        end
    end

`ifdef LIFO_WATERMARK_EN
    logic [c_CW-1:0] r_high_water;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high_water <= '0;
        end else if (err_clr) begin
            r_high_water <= r_count;
        end else if (r_count > r_high_water) begin
            r_high_water <= r_count;
        end
    end

    assign high_water = r_high_water;
`endif

    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= c_CW'(AF_THRESH));
    assign top         = w_empty ? '0 : w_rd_data;
    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_param_lifo_stack.sv
// +----------------------------------------------------------------------+
// | tb_param_lifo_stack : scoreboard bench for param_lifo_stack          |
// |                       (WIDTH=8, DEPTH=4, AF_THRESH=3)                |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_param_lifo_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic       err_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic [7:0] top;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       overflow;
    logic       underflow;
`ifdef LIFO_WATERMARK_EN
    logic [2:0] high_water;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_stk [$];
    logic [7:0] exp_q [$];
    logic [7:0] m_dout;
    logic       m_ovf;
    logic       m_unf;
    int         m_hw;

    always #5 clk = ~clk;

    param_lifo_stack #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .top         (top),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
`ifdef LIFO_WATERMARK_EN
        .high_water  (high_water),
`endif
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        exp_q.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_hw   = 0;
    endtask

    task automatic check_status(input string tag);
        int         sz;
        logic [7:0] exp_top;
        sz      = m_stk.size();
        exp_top = (sz > 0) ? m_stk[sz-1] : 8'h00;
        check_val({tag, ".count"},  32'(count),       32'(sz));
        check_val({tag, ".top"},    32'(top),         32'(exp_top));
        check_val({tag, ".full"},   32'(full),        32'(sz == DEPTH));
        check_val({tag, ".empty"},  32'(empty),       32'(sz == 0));
        check_val({tag, ".afull"},  32'(almost_full), 32'(sz >= AF));
        check_val({tag, ".ovf"},    32'(overflow),    32'(m_ovf));
        check_val({tag, ".unf"},    32'(underflow),   32'(m_unf));
`ifdef LIFO_WATERMARK_EN
        check_val({tag, ".hw"},     32'(high_water),  32'(m_hw));
`endif
    endtask

    // One clocked operation: update the model, drive, then compare after the edge
    task automatic do_op(input string tag, input logic p, input logic q,
                         input logic [7:0] d, input logic ec);
        int   cur;
        logic exp_dv;
        logic s_ovf;
        logic s_unf;
        cur    = m_stk.size();
        exp_dv = 1'b0;
        s_ovf  = 1'b0;
        s_unf  = 1'b0;
        if (p && !q) begin
            if (cur < DEPTH) m_stk.push_back(d);
            else s_ovf = 1'b1;
        end else if (!p && q) begin
            if (cur > 0) begin
                exp_q.push_back(m_stk.pop_back());
                exp_dv = 1'b1;
            end else begin
                s_unf = 1'b1;
            end
        end else if (p && q) begin
            if (cur > 0) begin
                exp_q.push_back(m_stk[cur-1]);
                m_stk[cur-1] = d;
            end else begin
                exp_q.push_back(d);
            end
            exp_dv = 1'b1;
        end
        m_ovf = s_ovf | (m_ovf & ~ec);
        m_unf = s_unf | (m_unf & ~ec);
        m_hw  = ec ? cur : ((cur > m_hw) ? cur : m_hw);

        @(negedge clk);
        push    = p;
        pop     = q;
        data_in = d;
        err_clr = ec;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;

        check_val({tag, ".dv"}, 32'(data_valid), 32'(exp_dv));
        if (exp_q.size() > 0) m_dout = exp_q.pop_front();
        check_val({tag, ".dout"}, 32'(data_out), 32'(m_dout));
        check_status(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 8'h00;
        err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst.dv",   32'(data_valid), 32'd0);
        check_val("rst.dout", 32'(data_out),   32'd0);
        check_status("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, then overflow
        do_op("push11", 1, 0, 8'h11, 0);
        do_op("push22", 1, 0, 8'h22, 0);
        do_op("push33", 1, 0, 8'h33, 0);
        do_op("push44", 1, 0, 8'h44, 0);
        do_op("push55_full", 1, 0, 8'h55, 0);

        // Drain in LIFO order
        for (int i = 0; i < 4; i++) do_op("pop_drain", 0, 1, 8'h00, 0);

        // Underflow and sticky-flag clearing
        do_op("pop_empty", 0, 1, 8'h00, 0);
        do_op("err_clr", 0, 0, 8'h00, 1);
        do_op("pop_empty_clr", 0, 1, 8'h00, 1);
        do_op("err_clr2", 0, 0, 8'h00, 1);

        // Swap on a partly filled and an empty stack
        do_op("pushA0", 1, 0, 8'hA0, 0);
        do_op("pushA1", 1, 0, 8'hA1, 0);
        do_op("swapB0", 1, 1, 8'hB0, 0);
        do_op("idle", 0, 0, 8'hEE, 0);
        do_op("popB0", 0, 1, 8'h00, 0);
        do_op("popA0", 0, 1, 8'h00, 0);
        do_op("swap_empty", 1, 1, 8'hC3, 0);

        // Swap while full must not raise overflow
        for (int i = 0; i < 4; i++) do_op("fill", 1, 0, 8'(8'h60 + i), 0);
        do_op("swap_full", 1, 1, 8'h7F, 0);
        for (int i = 0; i < 4; i++) do_op("drain", 0, 1, 8'h00, 0);

        // Random mix
        for (int i = 0; i < 60; i++) begin
            do_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), 1'($urandom_range(0, 7) == 0));
        end
        do_op("clr_pre", 0, 0, 8'h00, 1);
        while (m_stk.size() > 0) do_op("rand_drain", 0, 1, 8'h00, 0);

        // Asynchronous reset in the middle of a push at count 3
        do_op("pre_unf", 0, 1, 8'h00, 0);
        do_op("pre_p1", 1, 0, 8'h01, 0);
        do_op("pre_p2", 1, 0, 8'h02, 0);
        do_op("pre_p3", 1, 0, 8'h03, 0);
        @(negedge clk);
        push    = 1'b1;
        data_in = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("arst.dv",   32'(data_valid), 32'd0);
        check_val("arst.dout", 32'(data_out),   32'd0);
        check_status("arst");
        push = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_status("arst_rel");

        // Watermark sequence: push 3, pop 2, push 1, then err_clr
        do_op("wm_p1", 1, 0, 8'h91, 0);
        do_op("wm_p2", 1, 0, 8'h92, 0);
        do_op("wm_p3", 1, 0, 8'h93, 0);
        do_op("wm_q1", 0, 1, 8'h00, 0);
        do_op("wm_q2", 0, 1, 8'h00, 0);
        do_op("wm_p4", 1, 0, 8'h94, 0);
        do_op("wm_idle", 0, 0, 8'h00, 0);
`ifdef LIFO_WATERMARK_EN
        check_val("wm.hw3", 32'(high_water), 32'd3);
`endif
        do_op("wm_clr", 0, 0, 8'h00, 1);
`ifdef LIFO_WATERMARK_EN
        check_val("wm.hw2", 32'(high_water), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/param_lifo_stack.md
Name: param_lifo_stack

Overview:
- Parametrised LIFO stack; next generation of the team's 8x8 stack memory.
- Generalised WIDTH/DEPTH with a correctly sized pointer.
- Adds simultaneous push+pop (replace-top), a combinational top-of-stack peek, occupancy count, an almost-full flag and sticky overflow/underflow error flags.
- Sits between a producer/consumer pair as a local scratch stack (e.g. return-address or operand stack).

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2; not required to be a power of two).
- AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH (1..DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- push  in  1  push request.
- pop  in  1  pop request.
- data_in  in  WIDTH  push data.
- err_clr  in  1  clears sticky error flags.
- data_out  out  WIDTH  registered popped word.
- data_valid  out  1  one-cycle pulse; data_out updated this cycle.
- top  out  WIDTH  combinational peek of mem[count-1]; 0 when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- overflow  out  1  sticky: push rejected while full.
- underflow  out  1  sticky: pop rejected while empty.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low; clock port clk, reset port rst_n.
- Reset values: count=0, data_out=0, data_valid=0, overflow=0, underflow=0. Storage array is not reset; top is forced to 0 while empty, so stale data is never visible.
- Reset asserted mid-operation clears state immediately; the request in flight is discarded.
- Status: full/empty/almost_full/top are combinational from count and storage.
- Operation decode (push,pop): 00 IDLE, 10 PUSH, 01 POP, 11 SWAP.
- IDLE: no change; data_valid=0.
- PUSH, !full: mem[count] <= data_in; count+1.
- PUSH, full: no write, count unchanged, overflow <= 1.
- POP, !empty: data_out <= mem[count-1]; data_valid <= 1; count-1. Latency is 1 cycle; the popped word appears in the same cycle as the decremented count.
- POP, empty: data_out holds, data_valid=0, underflow <= 1.
- SWAP, !empty: data_out <= mem[count-1]; mem[count-1] <= data_in; data_valid <= 1; count unchanged. Legal even when full; never sets overflow.
- SWAP, empty: bypass. data_out <= data_in, data_valid <= 1, count stays 0, no flags set.
- Sticky flags: set on the error event, held until err_clr. If err_clr and a new error occur in the same cycle, set wins.
- Arithmetic: count is $clog2(DEPTH+1) bits wide so that DEPTH is representable. Read index is count-1, evaluated only when !empty. No wrap-around; count saturates at 0 and DEPTH via the rejection rules above.

Optional Feature:
- Macro: LIFO_WATERMARK_EN.
- Defined: adds output high_water [$clog2(DEPTH+1)] holding the maximum count reached since reset or err_clr. Reset value 0; updated the cycle after count rises; err_clr reloads it with the current count.
- Undefined: port and register are absent; all other behaviour is identical.

Decomposition:
- Package stack_pkg holds:
  - op encoding enum: OP_IDLE, OP_PUSH, OP_POP, OP_SWAP;
  - helper function for pointer width, clog2(DEPTH+1).
- One sub-module, lifo_regfile: WIDTH x DEPTH register array, one synchronous write port, one asynchronous read port. The top level holds the control FSM/counter and flags.

Test Plan (WIDTH=8, DEPTH=4, AF_THRESH=3):
- Reset then push 0x11,0x22,0x33,0x44 -> count 1..4; almost_full at count 3; full at 4; top=0x44.
- From full, push 0x55 -> count stays 4, overflow=1, top still 0x44; pop x4 -> data_out 0x44,0x33,0x22,0x11, each with a data_valid pulse; empty=1.
- Pop while empty -> underflow=1, data_valid=0, data_out holds 0x11; err_clr pulse -> underflow=0; err_clr coincident with a pop on empty -> underflow stays 1.
- Push 0xA0,0xA1 then SWAP with data_in 0xB0 -> data_out=0xA1, data_valid=1, count=2, top=0xB0; SWAP on empty with 0xC3 -> data_out=0xC3, count=0.
- Assert rst_n low asynchronously mid-push with count=3 -> count=0, flags 0, data_out=0 before the next clk edge; top=0.
- LIFO_WATERMARK_EN: push 3, pop 2, push 1 -> high_water=3; err_clr -> high_water=2.
